// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Optional feature macro used by this slice: MISALIGN_CHECK_EN (misaligned-access trap output).
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int REG_IDX_W  = 5;

    // Wait counter only has to hold MEM_LATENCY-1; keep at least one bit.
    function automatic int cnt_width(input int lat);
        return (lat < 3) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// EX/MEM inputs, MEM/WB outputs, store-data regfile port and stall/branch signals of the MEM stage.
// With MISALIGN_CHECK_EN defined the bundle carries the misalign flag as well.
interface memory_access_stage_if;
    import mem_stage_pkg::*;

    logic                 XM_MemtoReg;
    logic                 XM_RegWrite;
    logic                 XM_MemRead;
    logic                 XM_MemWrite;
    logic                 XM_branch;
    logic [31:0]          ALUout;
    logic [31:0]          XM_BT;
    logic [REG_IDX_W-1:0] XM_RD;
    logic [REG_IDX_W-1:0] XM_MD;
    logic [REG_IDX_W-1:0] sd_addr;
    logic [31:0]          sd_data;
    logic                 mem_stall;
    logic                 branch_taken;
    logic [31:0]          branch_target;
    logic                 MW_MemtoReg;
    logic                 MW_RegWrite;
    logic [REG_IDX_W-1:0] MW_RD;
    logic [31:0]          MW_ALUout;
    logic [31:0]          MW_MDR;
`ifdef MISALIGN_CHECK_EN
    logic                 misalign;
`endif

    // Upstream pipeline / register file side.
    modport master (
        output XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
        output ALUout, XM_BT, XM_RD, XM_MD, sd_data,
        input  sd_addr, mem_stall, branch_taken, branch_target,
        input  MW_MemtoReg, MW_RegWrite, MW_RD, MW_ALUout, MW_MDR
`ifdef MISALIGN_CHECK_EN
        , input misalign
`endif
    );

    // The MEM stage itself.
    modport slave (
        input  XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
        input  ALUout, XM_BT, XM_RD, XM_MD, sd_data,
        output sd_addr, mem_stall, branch_taken, branch_target,
        output MW_MemtoReg, MW_RegWrite, MW_RD, MW_ALUout, MW_MDR
`ifdef MISALIGN_CHECK_EN
        , output misalign
`endif
    );

endinterface

// File: rtl/dmem_array.sv
// Word-addressed data memory: single port, synchronous write, asynchronous read, contents never reset.
module dmem_array #(
    parameter int DMEM_WORDS = 256,
    parameter int AW         = $clog2(DMEM_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DMEM_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: data memory lw/sw with optional multi-cycle latency (stall handshake), MEM/WB register set.
// MISALIGN_CHECK_EN defined: misaligned completing accesses are suppressed and flagged on bus.misalign.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DMEM_WORDS  = 256,
    parameter int MEM_LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    memory_access_stage_if.slave bus
);

    localparam int AW  = $clog2(DMEM_WORDS);
    localparam int OFS = $clog2(WORD_BYTES);
    localparam int CW  = cnt_width(MEM_LATENCY);

    mem_state_t           r_state;
    mem_state_t           w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_next;
    logic                 w_mem_op;
    logic                 w_stall;
    logic                 w_complete;
    logic                 w_misaligned;
    logic                 w_suppress;
    logic                 w_we;
    logic                 w_load;
    logic [AW-1:0]        w_idx;
    logic [31:0]          w_rdata;

    logic                 r_memtoreg;
    logic                 r_regwrite;
    logic [REG_IDX_W-1:0] r_rd;
    logic [31:0]          r_aluout;
    logic [31:0]          r_mdr;

    assign w_mem_op = bus.XM_MemRead | bus.XM_MemWrite;
    assign w_idx    = bus.ALUout[OFS +: AW];

`ifdef MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_misaligned = |bus.ALUout[OFS-1:0];
    assign bus.misalign = r_misalign;
`else
    assign w_misaligned = 1'b0;
`endif

    // Completion is the only cycle in which XM_* and sd_data are consumed.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op && (MEM_LATENCY > 0)) begin
                    w_stall      = 1'b1;
                    w_state_next = WAIT;
                    w_cnt_next   = CW'(MEM_LATENCY - 1);
                end else begin
                    w_complete = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_suppress = w_complete & w_mem_op & w_misaligned;
    // Gate with rst so an access aborted by reset never lands in memory.
    assign w_we       = w_complete & bus.XM_MemWrite & ~w_suppress & ~rst;
    assign w_load     = w_complete & bus.XM_MemRead & ~bus.XM_MemWrite & ~w_suppress;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_aluout   <= '0;
            r_mdr      <= '0;
        end else if (w_complete) begin
            r_memtoreg <= bus.XM_MemtoReg;
            r_regwrite <= bus.XM_RegWrite & ~w_suppress;
            r_rd       <= bus.XM_RD;
            r_aluout   <= bus.ALUout;
            if (w_load) begin
                r_mdr <= w_rdata;
            end
        end else begin
            r_regwrite <= 1'b0;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_suppress;
        end
    end
`endif

    dmem_array #(
        .DMEM_WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (bus.sd_data),
        .o_rdata (w_rdata)
    );

    assign bus.sd_addr       = bus.XM_MD;
    assign bus.mem_stall     = w_stall;
    assign bus.branch_taken  = bus.XM_branch;
    assign bus.branch_target = bus.XM_BT;
    assign bus.MW_MemtoReg   = r_memtoreg;
    assign bus.MW_RegWrite   = r_regwrite;
    assign bus.MW_RD         = r_rd;
    assign bus.MW_ALUout     = r_aluout;
    assign bus.MW_MDR        = r_mdr;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage at latencies 0, 2 and 3; misalign case only with MISALIGN_CHECK_EN.
module tb_memory_access_stage;

    logic clk;
    logic rst;
    logic rst3;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n;

    memory_access_stage_if bus0 ();
    memory_access_stage_if bus2 ();
    memory_access_stage_if bus3 ();

    memory_access_stage #(.DMEM_WORDS(256), .MEM_LATENCY(0)) dut0 (.clk(clk), .rst(rst),  .bus(bus0.slave));
    memory_access_stage #(.DMEM_WORDS(256), .MEM_LATENCY(2)) dut2 (.clk(clk), .rst(rst),  .bus(bus2.slave));
    memory_access_stage #(.DMEM_WORDS(256), .MEM_LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    task automatic idle0();
        bus0.XM_MemtoReg = 0; bus0.XM_RegWrite = 0; bus0.XM_MemRead = 0; bus0.XM_MemWrite = 0;
        bus0.XM_branch = 0; bus0.ALUout = 0; bus0.XM_BT = 0; bus0.XM_RD = 0; bus0.XM_MD = 0; bus0.sd_data = 0;
    endtask

    task automatic idle2();
        bus2.XM_MemtoReg = 0; bus2.XM_RegWrite = 0; bus2.XM_MemRead = 0; bus2.XM_MemWrite = 0;
        bus2.XM_branch = 0; bus2.ALUout = 0; bus2.XM_BT = 0; bus2.XM_RD = 0; bus2.XM_MD = 0; bus2.sd_data = 0;
    endtask

    task automatic idle3();
        bus3.XM_MemtoReg = 0; bus3.XM_RegWrite = 0; bus3.XM_MemRead = 0; bus3.XM_MemWrite = 0;
        bus3.XM_branch = 0; bus3.ALUout = 0; bus3.XM_BT = 0; bus3.XM_RD = 0; bus3.XM_MD = 0; bus3.sd_data = 0;
    endtask

    initial begin
        rst = 1'b1;
        rst3 = 1'b1;
        idle0(); idle2(); idle3();
        #12;
        check_val("rst_mw_aluout0", bus0.MW_ALUout, 32'h0);
        check_val("rst_mw_regwr0", {31'b0, bus0.MW_RegWrite}, 32'h0);
        check_val("rst_mw_mdr0", bus0.MW_MDR, 32'h0);
        check_val("rst_mw_rd3", {27'b0, bus3.MW_RD}, 32'h0);
        check_val("rst_stall2", {31'b0, bus2.mem_stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        // LAT=0 store then load of the same word
        bus0.XM_MemWrite = 1; bus0.ALUout = 32'h10; bus0.XM_MD = 5'd5; bus0.sd_data = 32'hDEADBEEF;
        #1;
        check_val("t1_sd_addr", {27'b0, bus0.sd_addr}, 32'd5);
        check_val("t1_sw_stall", {31'b0, bus0.mem_stall}, 32'h0);
        @(posedge clk); #1;
        check_val("t1_sw_regwr", {31'b0, bus0.MW_RegWrite}, 32'h0);
        idle0();
        bus0.XM_MemRead = 1; bus0.XM_MemtoReg = 1; bus0.XM_RegWrite = 1; bus0.XM_RD = 5'd8; bus0.ALUout = 32'h10;
        #1;
        check_val("t1_lw_stall", {31'b0, bus0.mem_stall}, 32'h0);
        @(posedge clk); #1;
        check_val("t1_lw_mdr", bus0.MW_MDR, 32'hDEADBEEF);
        check_val("t1_lw_rd", {27'b0, bus0.MW_RD}, 32'd8);
        check_val("t1_lw_regwr", {31'b0, bus0.MW_RegWrite}, 32'h1);
        check_val("t1_lw_m2r", {31'b0, bus0.MW_MemtoReg}, 32'h1);

        // ALU op passes through, no stall, MDR held
        idle0();
        bus0.XM_RegWrite = 1; bus0.XM_RD = 5'd3; bus0.ALUout = 32'h1234;
        #1;
        check_val("t3_stall", {31'b0, bus0.mem_stall}, 32'h0);
        @(posedge clk); #1;
        check_val("t3_aluout", bus0.MW_ALUout, 32'h1234);
        check_val("t3_rd", {27'b0, bus0.MW_RD}, 32'd3);
        check_val("t3_mdr_held", bus0.MW_MDR, 32'hDEADBEEF);

`ifdef MISALIGN_CHECK_EN
        idle0();
        bus0.XM_MemWrite = 1; bus0.ALUout = 32'h13; bus0.sd_data = 32'h00000099;
        @(posedge clk); #1;
        check_val("t6_misalign_set", {31'b0, bus0.misalign}, 32'h1);
        idle0();
        @(posedge clk); #1;
        check_val("t6_misalign_clr", {31'b0, bus0.misalign}, 32'h0);
`endif

        // 0x410 aliases word 0x10 in a 256-word memory
        idle0();
        bus0.XM_MemRead = 1; bus0.XM_MemtoReg = 1; bus0.XM_RegWrite = 1; bus0.XM_RD = 5'd1; bus0.ALUout = 32'h410;
        @(posedge clk); #1;
        check_val("t6_alias_mdr", bus0.MW_MDR, 32'hDEADBEEF);

        idle0();
        bus0.XM_branch = 1; bus0.XM_BT = 32'h40;
        #1;
        check_val("t4_br_taken", {31'b0, bus0.branch_taken}, 32'h1);
        check_val("t4_br_target", bus0.branch_target, 32'h40);
        bus0.XM_branch = 0;
        #1;
        check_val("t4_br_clear", {31'b0, bus0.branch_taken}, 32'h0);
        @(posedge clk); #1;

        // LAT=2: store, then load with a branch presented during the stall
        bus2.XM_MemWrite = 1; bus2.ALUout = 32'h8; bus2.sd_data = 32'hCAFEF00D;
        n = 0;
        #1;
        while (bus2.mem_stall && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_val("t2_sw_stall_cycles", n, 32'd2);
        idle2();
        bus2.XM_MemRead = 1; bus2.XM_MemtoReg = 1; bus2.XM_RegWrite = 1; bus2.XM_RD = 5'd9; bus2.ALUout = 32'h8;
        bus2.XM_branch = 1; bus2.XM_BT = 32'h80;
        #1;
        check_val("t2_stall_c0", {31'b0, bus2.mem_stall}, 32'h1);
        check_val("t4_stall_target", bus2.branch_target, 32'h80);
        @(posedge clk); #1;
        check_val("t2_bubble1", {31'b0, bus2.MW_RegWrite}, 32'h0);
        check_val("t2_stall_c1", {31'b0, bus2.mem_stall}, 32'h1);
        check_val("t4_stall_taken", {31'b0, bus2.branch_taken}, 32'h1);
        @(posedge clk); #1;
        check_val("t2_bubble2", {31'b0, bus2.MW_RegWrite}, 32'h0);
        check_val("t2_stall_c2", {31'b0, bus2.mem_stall}, 32'h0);
        @(posedge clk); #1;
        check_val("t2_lw_regwr", {31'b0, bus2.MW_RegWrite}, 32'h1);
        check_val("t2_lw_mdr", bus2.MW_MDR, 32'hCAFEF00D);
        check_val("t2_lw_rd", {27'b0, bus2.MW_RD}, 32'd9);
        idle2();

        // LAT=3: committed store, then a store aborted by reset mid-WAIT
        bus3.XM_MemWrite = 1; bus3.ALUout = 32'h20; bus3.sd_data = 32'h11111111;
        n = 0;
        #1;
        while (bus3.mem_stall && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_val("t5_sw1_stall_cycles", n, 32'd3);
        bus3.sd_data = 32'h22222222;
        #1;
        check_val("t5_sw2_stall", {31'b0, bus3.mem_stall}, 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle3();
        rst3 = 1'b1;
        #1;
        check_val("t5_rst_aluout", bus3.MW_ALUout, 32'h0);
        check_val("t5_rst_stall", {31'b0, bus3.mem_stall}, 32'h0);
        @(posedge clk); #1;
        rst3 = 1'b0;
        bus3.XM_MemRead = 1; bus3.XM_MemtoReg = 1; bus3.XM_RegWrite = 1; bus3.XM_RD = 5'd4; bus3.ALUout = 32'h20;
        n = 0;
        #1;
        while (bus3.mem_stall && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_val("t5_lw_stall_cycles", n, 32'd3);
        check_val("t5_lw_mdr", bus3.MW_MDR, 32'h11111111);
        check_val("t5_lw_rd", {27'b0, bus3.MW_RD}, 32'd4);
        idle3();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
